atmo_light_est: RTL

- Parametrised, pipelined atmospheric-light (A) estimator for the dark-channel-prior dehaze chain.
- Runs in parallel with the dark-channel block. For each frame it tracks the pixel with the brightest dark-channel value and latches that pixel's per-channel colour.
- At frame end it emits per-channel A, the max-of-channels A, and a one-cycle valid strobe. These feed the transmission-map stage of the next frame.
- Generalises the earlier fixed 8-bit RGB channel-extremum logic to N channels with configurable width, tie policy and output clamp.

---
 rtl/atmo_light_est_pkg.sv | 28 ++
 rtl/atmo_light_est_if.sv | 27 ++
 rtl/atmo_light_est_ch_max_tree.sv | 31 +++
 rtl/atmo_light_est.sv | 120 ++++++++++++
 4 files changed

// File: rtl/atmo_light_est_pkg.sv
// atmo_light_est_pkg: shared widths, frame state and channel helpers for the dehaze chain.
package atmo_light_est_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int CH_DEF = 3;
    localparam int MAX_W = 32;
    localparam int MAX_CH = 16;

    typedef logic [MAX_CH*MAX_W-1:0] ch_vec_t;
    typedef enum logic {ST_IDLE, ST_BUSY} frm_st_t;

    // Channel 0 sits in the MSBs, so lane c starts (ch-1-c) lanes up from bit 0.
    function automatic int ch_lsb(input int c, input int ch, input int w);
        return (ch - 1 - c) * w;
    endfunction

    function automatic logic [MAX_W-1:0] max_of_n(input ch_vec_t v, input int n, input int w);
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] x;
        m = '0;
        for (int c = 0; c < MAX_CH; c++) begin
            if (c < n) begin
                x = MAX_W'(v >> ch_lsb(c, n, w)) & MAX_W'((64'd1 << w) - 64'd1);
                if (x > m) m = x;
            end
        end
        return m;
    endfunction
endpackage

// File: rtl/atmo_light_est_if.sv
// atmo_light_est_if: pixel/dark-channel stream in, atmospheric-light result out.
interface atmo_light_est_if
    import atmo_light_est_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH = CH_DEF
);
    logic                 frame_start;
    logic                 frame_end;
    logic                 pix_valid;
    logic [CH*DATA_W-1:0] pix_rgb;
    logic [DATA_W-1:0]    dark_data;
    logic [CH*DATA_W-1:0] a_ch;
    logic [DATA_W-1:0]    a_max;
    logic                 a_valid;
    logic                 a_hit;
    logic                 busy;

    modport master (
        output frame_start, frame_end, pix_valid, pix_rgb, dark_data,
        input  a_ch, a_max, a_valid, a_hit, busy
    );
    modport slave (
        input  frame_start, frame_end, pix_valid, pix_rgb, dark_data,
        output a_ch, a_max, a_valid, a_hit, busy
    );
endinterface

// File: rtl/atmo_light_est_ch_max_tree.sv
// ch_max_tree: unsigned max over N packed W-bit lanes, optionally registered.
module ch_max_tree
    import atmo_light_est_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 3,
    parameter int PIPE = 0
)(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N*W-1:0] i_v,
    output logic [W-1:0]   o_max
);
    logic [W-1:0] w_max;

    assign w_max = W'(max_of_n(ch_vec_t'(i_v), N, W));

    generate
        if (PIPE != 0) begin : g_pipe
            logic [W-1:0] r_max;
            always_ff @(posedge i_clk) begin
                r_max <= i_rst ? '0 : w_max;
            end
            assign o_max = r_max;
        end else begin : g_comb
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_max = w_max;
        end
    endgenerate
endmodule

// File: rtl/atmo_light_est.sv
// atmo_light_est: per-frame atmospheric light from the brightest dark-channel pixel.
module atmo_light_est
    import atmo_light_est_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH = CH_DEF,
    parameter int TIE_LAST = 0,
    parameter int A_LIMIT = 255
)(
    input logic sys_clk,
    input logic sys_rst,
    atmo_light_est_if.slave bus
);
    localparam logic [DATA_W-1:0] LIM = DATA_W'(A_LIMIT);

    logic                 r_s1_start, r_s1_end, r_s1_pv;
    logic [CH*DATA_W-1:0] r_s1_rgb;
    logic [DATA_W-1:0]    r_s1_dark;
    frm_st_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]    r_best_dark, w_base_dark, w_new_dark;
    logic [CH*DATA_W-1:0] r_best_rgb, w_base_rgb, w_new_rgb;
    logic                 r_seen, w_base_seen, w_new_seen;
    logic                 w_open, w_fresh, w_restart, w_upd, w_close;
    logic                 r_s2_valid, r_snap_seen;
    logic [CH*DATA_W-1:0] r_snap_rgb, w_clamp;
    logic [DATA_W-1:0]    w_clamp_max;
    logic [CH*DATA_W-1:0] r_a_ch;
    logic [DATA_W-1:0]    r_a_max;
    logic                 r_a_valid, r_a_hit;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s1_start <= 1'b0;
            r_s1_end   <= 1'b0;
            r_s1_pv    <= 1'b0;
            r_s1_rgb   <= '0;
            r_s1_dark  <= '0;
        end else begin
            r_s1_start <= bus.frame_start;
            r_s1_end   <= bus.frame_end;
            r_s1_pv    <= bus.pix_valid;
            r_s1_rgb   <= bus.pix_rgb;
            r_s1_dark  <= bus.dark_data;
        end
    end

    // A start coinciding with an end while busy closes the running frame instead of clearing it.
    always_comb begin
        w_open      = (r_state == ST_BUSY) || r_s1_start;
        w_fresh     = r_s1_start && !(r_s1_end && r_state == ST_BUSY);
        w_restart   = r_s1_start && r_s1_end;
        w_base_dark = w_fresh ? '0 : r_best_dark;
        w_base_rgb  = w_fresh ? '0 : r_best_rgb;
        w_base_seen = !w_fresh && r_seen;
        w_upd       = r_s1_pv && w_open && (!w_base_seen || r_s1_dark > w_base_dark
                      || (TIE_LAST != 0 && r_s1_dark == w_base_dark));
        w_new_dark  = w_upd ? r_s1_dark : w_base_dark;
        w_new_rgb   = w_upd ? r_s1_rgb : w_base_rgb;
        w_new_seen  = w_upd || w_base_seen;
        w_close     = r_s1_end && w_open;
        w_state_nxt = r_s1_start ? ST_BUSY : (r_s1_end ? ST_IDLE : r_state);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_best_dark <= '0;
            r_best_rgb  <= '0;
            r_seen      <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_snap_rgb  <= '0;
            r_snap_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_best_dark <= w_restart ? '0 : w_new_dark;
            r_best_rgb  <= w_restart ? '0 : w_new_rgb;
            r_seen      <= !w_restart && w_new_seen;
            r_s2_valid  <= w_close;
            if (w_close) begin
                r_snap_rgb  <= w_new_rgb;
                r_snap_seen <= w_new_seen;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_clamp
        localparam int LSB = ch_lsb(c, CH, DATA_W);
        assign w_clamp[LSB +: DATA_W] = (r_snap_rgb[LSB +: DATA_W] > LIM) ? LIM : r_snap_rgb[LSB +: DATA_W];
    end

    ch_max_tree #(.W(DATA_W), .N(CH), .PIPE(0)) u_max (
        .i_clk (sys_clk),
        .i_rst (sys_rst),
        .i_v   (w_clamp),
        .o_max (w_clamp_max)
    );

    // An empty frame still strobes but keeps the previous colour.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_a_valid <= 1'b0;
            r_a_hit   <= 1'b0;
            r_a_ch    <= '0;
            r_a_max   <= '0;
        end else begin
            r_a_valid <= r_s2_valid;
            if (r_s2_valid) r_a_hit <= r_snap_seen;
            if (r_s2_valid && r_snap_seen) begin
                r_a_ch  <= w_clamp;
                r_a_max <= w_clamp_max;
            end
        end
    end

    assign bus.a_ch    = r_a_ch;
    assign bus.a_max   = r_a_max;
    assign bus.a_valid = r_a_valid;
    assign bus.a_hit   = r_a_hit;
    assign bus.busy    = (r_state == ST_BUSY);
endmodule
